// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared state type and sizing helpers for the digit-serial adder
package seq_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Number of digit steps per operation
    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width, never narrower than one bit
    function automatic int cnt_w(input int width, input int digit);
        return (width / digit > 1) ? $clog2(width / digit) : 1;
    endfunction

    // Legal geometry: DIGIT in 1..WIDTH and WIDTH an exact multiple of DIGIT
    function automatic bit width_ok(input int width, input int digit);
        return digit >= 1 && digit <= width && width % digit == 0;
    endfunction

endpackage

// File: rtl/seq_adder_digit_add.sv
// digit_add: combinational DIGIT-bit adder slice with carry in and out
module digit_add #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    assign {co, s} = (DIGIT+1)'(x) + (DIGIT+1)'(y) + (DIGIT+1)'(ci);

endmodule

// File: rtl/seq_adder.sv
// seq_adder: digit-serial a + b + cin with valid/ready on both sides; SEQ_ADDER_SUB_EN adds a subtract mode
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_w(WIDTH, DIGIT);

    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_geometry
        $error("seq_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [DIGIT-1:0] ds;
    logic             dco;

    // Subtraction is folded into the latched operands: a + ~b + 1
`ifdef SEQ_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    // Operand registers shift right so the active digit always sits at bit 0;
    // carry doubles as the running carry and ends as the final carry-out
    digit_add #(.DIGIT(DIGIT)) u_digit (
        .x (ra[DIGIT-1:0]),
        .y (rb[DIGIT-1:0]),
        .ci(carry),
        .s (ds),
        .co(dco)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // Control FSM and datapath: accept, step NDIG digits, hold result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            ra    <= '0;
            rb    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra    <= a;
                    rb    <= b_in;
                    carry <= c_in;
                    cnt   <= '0;
                    sum   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    ra    <= ra >> DIGIT;
                    rb    <= rb >> DIGIT;
                    sum   <= (sum >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));
                    carry <= dco;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NDIG - 1))
                        state <= DONE;
                end
                DONE: if (out_ready)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: directed vectors plus an arithmetic reference model for seq_adder
module tb_seq_adder;

    localparam int W    = 8;
    localparam int NDIG = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b1;
    logic         iv_s = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef SEQ_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         in_ready, out_valid, carry;
    logic [W-1:0] sum;
    logic         r1, v1, c1, r8, v8, c8;
    logic [W-1:0] s1, s8;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_adder #(.WIDTH(W), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry)
    );

    seq_adder #(.WIDTH(W), .DIGIT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(r1),
        .a(a), .b(b), .cin(cin),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(v1), .out_ready(out_ready), .sum(s1), .carry(c1)
    );

    seq_adder #(.WIDTH(W), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(r8),
        .a(a), .b(b), .cin(cin),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(v8), .out_ready(out_ready), .sum(s8), .carry(c8)
    );

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Reference: one operation at a time, result ready NDIG edges after acceptance
    logic       m_busy = 1'b0;
    int         m_age = 0;
    logic [W:0] m_res = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
`ifdef SEQ_ADDER_SUB_EN
                m_res  <= sub ? (W+1)'(a) + (W+1)'(~b) + (W+1)'(1)
                              : (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
`else
                m_res  <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
`endif
            end
        end else if (m_age >= NDIG && out_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    // Per-cycle comparison of the main instance against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", int'(in_ready), int'(!m_busy));
            check("out_valid", int'(out_valid), int'(m_busy && m_age >= NDIG));
            if (m_busy && m_age >= NDIG) begin
                check("sum", int'(sum), int'(m_res[W-1:0]));
                check("carry", int'(carry), int'(m_res[W]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation; operands are scrambled while it runs
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, output int lat);
        a = ta;
        b = tb;
        cin = tc;
        in_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            lat++;
            if (out_valid) break;
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
`ifdef SEQ_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
        end
        in_valid = 1'b0;
        if (!out_valid) check("op_timeout", 0, 1);
    endtask

    task automatic op_check(input string n, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                            input int es, input int ec);
        int lat;
        run_op(ta, tb, tc, lat);
        check({n, "_lat"}, lat, NDIG + 1);
        check({n, "_sum"}, int'(sum), es);
        check({n, "_carry"}, int'(carry), ec);
        step();
    endtask

    initial begin
        int lat, l1, l8, n;
        step();
        step();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_carry", int'(carry), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        op_check("add_5_1", 8'd5, 8'd1, 1'b0, 6, 0);
        op_check("add_200_100", 8'd200, 8'd100, 1'b0, 44, 1);
        op_check("add_255_255_1", 8'd255, 8'd255, 1'b1, 255, 1);

        out_ready = 1'b0;
        run_op(8'd9, 8'd4, 1'b1, lat);
        check("bp_sum0", int'(sum), 14);
        repeat (3) step();
        check("bp_valid", int'(out_valid), 1);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_sum", int'(sum), 14);
        check("bp_carry", int'(carry), 0);
        out_ready = 1'b1;
        step();
        check("bp_release_ready", int'(in_ready), 1);
        check("bp_release_valid", int'(out_valid), 0);

        a = 8'd50;
        b = 8'd60;
        cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_sum", int'(sum), 0);
        check("midrst_carry", int'(carry), 0);
        check("midrst_ready", int'(in_ready), 1);
        op_check("add_3_7", 8'd3, 8'd7, 1'b0, 10, 0);

`ifdef SEQ_ADDER_SUB_EN
        sub = 1'b1;
        op_check("sub_3_7", 8'd3, 8'd7, 1'b0, 252, 0);
        sub = 1'b1;
        op_check("sub_7_3", 8'd7, 8'd3, 1'b1, 4, 1);
        sub = 1'b0;
        op_check("nosub_7_3", 8'd7, 8'd3, 1'b1, 11, 0);
`endif

        check("sweep1_ready", int'(r1), 1);
        check("sweep8_ready", int'(r8), 1);
        a = 8'd170;
        b = 8'd85;
        cin = 1'b1;
        iv_s = 1'b1;
        l1 = 0;
        l8 = 0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            n++;
            iv_s = 1'b0;
            if (v1 && l1 == 0) begin
                l1 = n;
                check("sweep1_sum", int'(s1), 0);
                check("sweep1_carry", int'(c1), 1);
            end
            if (v8 && l8 == 0) begin
                l8 = n;
                check("sweep8_sum", int'(s8), 0);
                check("sweep8_carry", int'(c8), 1);
            end
            if (l1 != 0 && l8 != 0) break;
        end
        check("sweep1_lat", l1, 2);
        check("sweep8_lat", l8, 9);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
